smg_avm_master: RTL and testbench

- Avalon-MM master (initiator) that drives the 7-segment display slave in hardware, with no Nios II software involved.
- Takes a 6-digit hex/BCD value plus decimal points and encodes each digit to a segment code.
- Writes the two 32-bit segment registers of the display slave (word 0 = digits 0-3, word 1 = digits 4-7), then optionally reads both back and compares.
- Sits beside the display slave on the same Qsys/Avalon fabric, triggered by a start pulse or an internal refresh timer.

---
 rtl/smg_pkg.sv | 25 ++
 rtl/smg_seg_encode.sv | 13 +
 rtl/smg_avm_master.sv | 160 ++++++++++++++++
 tb/tb_smg_avm_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared types and constants for the 7-segment Avalon-MM master: FSM states,
// the active-low segment table and the slave word offsets.
package smg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR0,
        WR1,
        RD0,
        RD1,
        DONE
    } state_e;

    // Active-low codes for hex digits 0-F; bit 7 (dp) is off in every entry.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [31:0] WORD0_OFS = 32'd0;
    localparam logic [31:0] WORD1_OFS = 32'd4;

endpackage

// File: rtl/smg_seg_encode.sv
// Combinational encoder: one hex digit plus its decimal point to an
// active-low segment byte {dp, g..a}.
module smg_seg_encode
    import smg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, SEG_CODES[digit_i][6:0]};

endmodule

// File: rtl/smg_avm_master.sv
// Avalon-MM master that encodes a 6-digit value and writes the two segment
// words of the display slave, optionally reading both back to verify them.
module smg_avm_master
    import smg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned REFRESH_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          VERIFY         = 1'b1
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic [23:0] coe_value,
    input  logic [5:0]  coe_dp,
    input  logic        coe_start,
    output logic        coe_busy,
    output logic        coe_done,
    output logic        coe_err
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [23:0]      value_q, value_d;
    logic [5:0]       dp_q, dp_d;
    logic             err_q, err_d;

    logic [7:0]  seg [6];
    logic [31:0] word0, word1;
    logic        ref_tick, in_xfer, timeout_hit;

    for (genvar i = 0; i < 6; i++) begin : g_enc
        smg_seg_encode u_enc (
            .digit_i (value_q[4*i +: 4]),
            .dp_i    (dp_q[i]),
            .seg_o   (seg[i])
        );
    end

    assign word0 = {seg[3], seg[2], seg[1], seg[0]};
    assign word1 = {SEG_BLANK, SEG_BLANK, seg[5], seg[4]};

    // The refresh timer free-runs in every state; ticks outside IDLE are simply lost.
    assign ref_tick    = (REFRESH_CYCLES != 0) && (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
    assign in_xfer     = (state_q == WR0) || (state_q == WR1) || (state_q == RD0) || (state_q == RD1);
    assign timeout_hit = in_xfer && avm_waitrequest && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        value_d    = value_q;
        dp_d       = dp_q;
        err_d      = err_q;
        ref_cnt_d  = (REFRESH_CYCLES == 0 || ref_tick) ? '0 : ref_cnt_q + 1'b1;
        wait_cnt_d = (in_xfer && avm_waitrequest && !timeout_hit) ? wait_cnt_q + 1'b1 : '0;

        case (state_q)
            IDLE: if (coe_start || ref_tick) state_d = LOAD;
            LOAD: begin
                value_d = coe_value;
                dp_d    = coe_dp;
                err_d   = 1'b0;
                state_d = WR0;
            end
            WR0:  if (!avm_waitrequest) state_d = WR1;
            WR1:  if (!avm_waitrequest) state_d = VERIFY ? RD0 : DONE;
            RD0: begin
                if (!avm_waitrequest) begin
                    if (avm_readdata != word0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                if (!avm_waitrequest) begin
                    if (avm_readdata != word1) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    // Bus outputs decode straight from state_q, so reset clears them at the next edge.
    always_comb begin
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (state_q)
            WR0: begin
                avm_write     = 1'b1;
                avm_address   = BASE_ADDR + WORD0_OFS;
                avm_writedata = word0;
            end
            WR1: begin
                avm_write     = 1'b1;
                avm_address   = BASE_ADDR + WORD1_OFS;
                avm_writedata = word1;
            end
            RD0: begin
                avm_read    = 1'b1;
                avm_address = BASE_ADDR + WORD0_OFS;
            end
            RD1: begin
                avm_read    = 1'b1;
                avm_address = BASE_ADDR + WORD1_OFS;
            end
            default: ;
        endcase
        avm_byteenable = (avm_read || avm_write) ? 4'hF : 4'h0;
    end

    assign coe_busy = (state_q != IDLE) && (state_q != DONE);
    assign coe_done = (state_q == DONE);
    assign coe_err  = err_q;

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            state_q    <= IDLE;
            ref_cnt_q  <= '0;
            wait_cnt_q <= '0;
            value_q    <= '0;
            dp_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_smg_avm_master.sv
// Directed bench for smg_avm_master: a verifying instance driven step by step
// and a non-verifying instance running from its 100-cycle refresh timer.
module tb_smg_avm_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic [3:0]  avm_byteenable;
    logic        avm_write, avm_read, avm_waitrequest;
    logic [23:0] value;
    logic [5:0]  dp;
    logic        start, busy, done, err;

    logic [31:0] r_address, r_writedata;
    logic [3:0]  r_byteenable;
    logic        r_write, r_read, r_start, r_busy, r_done, r_err;
    logic [31:0] r_readdata = 32'h0;
    logic        r_waitrequest = 1'b0;
    logic [23:0] r_value = 24'h000000;
    logic [5:0]  r_dp = 6'b000000;

    smg_avm_master #(
        .BASE_ADDR(32'h0000_1000), .REFRESH_CYCLES(0), .TIMEOUT_CYCLES(1023), .VERIFY(1'b1)
    ) dut (
        .csi_clk(clk), .csi_reset(rst),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .coe_value(value), .coe_dp(dp), .coe_start(start),
        .coe_busy(busy), .coe_done(done), .coe_err(err)
    );

    smg_avm_master #(
        .BASE_ADDR(32'h0000_0000), .REFRESH_CYCLES(100), .TIMEOUT_CYCLES(1023), .VERIFY(1'b0)
    ) dut_r (
        .csi_clk(clk), .csi_reset(rst),
        .avm_address(r_address), .avm_byteenable(r_byteenable), .avm_write(r_write),
        .avm_writedata(r_writedata), .avm_read(r_read), .avm_readdata(r_readdata),
        .avm_waitrequest(r_waitrequest),
        .coe_value(r_value), .coe_dp(r_dp), .coe_start(r_start),
        .coe_busy(r_busy), .coe_done(r_done), .coe_err(r_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Slave model and bus monitor for the verifying instance.
    logic [31:0] mem0 = 32'h0, mem1 = 32'h0, corrupt = 32'h0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          n_wr = 0, n_rd = 0, n_wr_hi = 0, proto_bad = 0;
    logic        prev_hold = 1'b0;
    logic [65:0] prev_bus = '0;

    assign avm_readdata = avm_address[2] ? (mem1 ^ corrupt) : mem0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (avm_write && !avm_waitrequest) begin
            log_addr[n_wr % 64] = avm_address;
            log_data[n_wr % 64] = avm_writedata;
            if (avm_address[2]) mem1 = avm_writedata;
            else                mem0 = avm_writedata;
            n_wr++;
        end
        if (avm_read && !avm_waitrequest) n_rd++;
        if (avm_write) n_wr_hi++;
        if (avm_read && avm_write) proto_bad++;
        if ((avm_read || avm_write) && avm_byteenable !== 4'hF) proto_bad++;
        if (prev_hold && (avm_read || avm_write) &&
            {avm_read, avm_write, avm_address, avm_writedata} !== prev_bus) proto_bad++;
        prev_hold = (avm_read || avm_write) && avm_waitrequest && !rst;
        prev_bus  = {avm_read, avm_write, avm_address, avm_writedata};
    end

    // Monitor for the refresh-driven instance.
    int r_done_log [16];
    int r_ndone = 0, r_nwr = 0, r_bad = 0;

    always @(negedge clk) begin
        if (r_done) begin
            r_done_log[r_ndone % 16] = cyc;
            r_ndone++;
        end
        if (r_write) r_nwr++;
        if (r_read) r_bad++;
        if (r_write && (r_byteenable !== 4'hF ||
            (r_address !== 32'h0 && r_address !== 32'h4) ||
            (r_writedata !== 32'hC0C0C0C0 && r_writedata !== 32'hFFFFC0C0))) r_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int lat, output bit got_done);
        lat      = 0;
        got_done = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            step();
            start = 1'b0;
            if (done) begin
                lat      = i;
                got_done = 1'b1;
                break;
            end
            if (!busy) begin
                lat = i;
                break;
            end
        end
        check("seq_ends_in_budget", 32'(lat != 0), 32'd1);
    endtask

    task automatic run_seq(input int budget, output int lat, output bit got_done);
        start = 1'b1;
        wait_done(budget, lat, got_done);
    endtask

    task automatic wait_r_done(input int want, input int budget);
        int i = 0;
        while (r_ndone < want && i < budget) begin
            step();
            i++;
        end
        check("r_done_in_budget", 32'(r_ndone >= want), 32'd1);
    endtask

    initial begin
        int  lat, wbase, rbase, hbase, rel, r_base, r_wbase, l1, l2;
        bit  gd;

        rst = 1'b1; start = 1'b0; r_start = 1'b0; avm_waitrequest = 1'b0;
        value = 24'h0; dp = 6'h0;
        step();
        step();
        check("rst_write", avm_write, 0);
        check("rst_read", avm_read, 0);
        check("rst_address", avm_address, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_byteenable", avm_byteenable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Basic sequence, no stalls: 6-cycle latency with read-back.
        value = 24'h123456; dp = 6'b000000;
        wbase = n_wr; rbase = n_rd;
        run_seq(20, lat, gd);
        check("t1_latency", lat, 6);
        check("t1_done", gd, 1);
        check("t1_err", err, 0);
        check("t1_w0_addr", log_addr[wbase % 64], 32'h0000_1000);
        check("t1_w0_data", log_data[wbase % 64], 32'hB099_9282);
        check("t1_w1_addr", log_addr[(wbase + 1) % 64], 32'h0000_1004);
        check("t1_w1_data", log_data[(wbase + 1) % 64], 32'hFFFF_F9A4);
        check("t1_reads", n_rd - rbase, 2);
        step();
        check("t1_done_one_cycle", done, 0);

        // Hex letters and a lit decimal point on digit 0.
        value = 24'hABCDEF; dp = 6'b000001;
        wbase = n_wr;
        run_seq(20, lat, gd);
        check("t2_done", gd, 1);
        check("t2_w0_data", log_data[wbase % 64], 32'hC6A1_860E);
        check("t2_w1_data", log_data[(wbase + 1) % 64], 32'hFFFF_8883);
        step();

        // Three waitrequest cycles on WR0.
        value = 24'h123456; dp = 6'b000000;
        wbase = n_wr; hbase = n_wr_hi;
        start = 1'b1;
        step();
        start = 1'b0;
        avm_waitrequest = 1'b1;
        step();
        check("t3_wr0_write", avm_write, 1);
        check("t3_wr0_addr", avm_address, 32'h0000_1000);
        check("t3_wr0_data", avm_writedata, 32'hB099_9282);
        step();
        step();
        step();
        avm_waitrequest = 1'b0;
        check("t3_wr0_still_write", avm_write, 1);
        check("t3_wr0_still_addr", avm_address, 32'h0000_1000);
        wait_done(10, lat, gd);
        check("t3_rest_latency", lat, 4);
        check("t3_done", gd, 1);
        check("t3_accepted_writes", n_wr - wbase, 2);
        check("t3_write_high_cycles", n_wr_hi - hbase, 5);
        step();

        // Corrupted read-back of word 1.
        corrupt = 32'h0000_0001;
        rbase = n_rd;
        run_seq(20, lat, gd);
        check("t4_no_done", gd, 0);
        check("t4_abort_cycle", lat, 6);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_reads", n_rd - rbase, 2);
        corrupt = 32'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t4_err_cleared", err, 0);
        wait_done(20, lat, gd);
        check("t4_recover_done", gd, 1);
        step();

        // Waitrequest stuck high.
        avm_waitrequest = 1'b1;
        wbase = n_wr; hbase = n_wr_hi;
        run_seq(1100, lat, gd);
        avm_waitrequest = 1'b0;
        check("t5_no_done", gd, 0);
        check("t5_abort_cycle", lat, 1025);
        check("t5_write_high_cycles", n_wr_hi - hbase, 1023);
        check("t5_no_accepted_write", n_wr - wbase, 0);
        check("t5_write_dropped", avm_write, 0);
        check("t5_err", err, 1);
        check("t5_busy", busy, 0);
        rst = 1'b1;
        step();
        check("t5_rst_clears_err", err, 0);
        rst = 1'b0;
        step();

        // Reset asserted in RD0.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("t6_in_rd0_read", avm_read, 1);
        check("t6_in_rd0_addr", avm_address, 32'h0000_1000);
        rst = 1'b1;
        step();
        check("t6_read", avm_read, 0);
        check("t6_write", avm_write, 0);
        check("t6_address", avm_address, 0);
        check("t6_byteenable", avm_byteenable, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        rel = cyc; r_base = r_ndone; r_wbase = r_nwr;
        rst = 1'b0;
        step();

        // Refresh instance: first tick 100 cycles after reset, 4-cycle sequence.
        wait_r_done(r_base + 1, 150);
        l1 = r_done_log[r_base % 16];
        check("r_first_done_cycle", l1, rel + 103);
        while (cyc < l1 + 98) step();
        check("r_busy_before_start", r_busy, 1);
        r_start = 1'b1;
        step();
        r_start = 1'b0;
        wait_r_done(r_base + 2, 150);
        l2 = r_done_log[(r_base + 1) % 16];
        check("r_period_start_ignored", l2, l1 + 100);
        while (cyc < l2 + 96) step();
        r_start = 1'b1;
        step();
        r_start = 1'b0;
        wait_r_done(r_base + 3, 150);
        check("r_start_with_tick", r_done_log[(r_base + 2) % 16], l2 + 100);
        while (cyc < l2 + 130) step();
        check("r_sequence_count", r_ndone - r_base, 3);
        check("r_write_cycles", r_nwr - r_wbase, 6);
        check("r_err", r_err, 0);
        check("r_bus_rules", r_bad, 0);
        check("bus_rules", proto_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
